// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage instruction fields in, pipeline control out.
//   master: side that presents the D instruction and consumes stall/forwarding
//   slave : the hazard unit itself
//   D_op/D_fuc/D_rs/D_rt/D_rd : decoded fields of the instruction in D
//   stall                     : freeze PC and F/D, bubble into D/E
//   D_FWD_rs/D_FWD_rt         : D source select (0 GRF, 1 M, 2 E)
//   E_FWD_A1/E_FWD_A2         : E source select (0 pipe reg, 1 M, 2 W)
//   M_FWD_WD                  : M store data select (0 pipe reg, 1 W)
interface hazard_ctrl_if;
    logic [5:0] D_op;
    logic [5:0] D_fuc;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [4:0] D_rd;
    logic       stall;
    logic [1:0] D_FWD_rs;
    logic [1:0] D_FWD_rt;
    logic [1:0] E_FWD_A1;
    logic [1:0] E_FWD_A2;
    logic       M_FWD_WD;

    modport master (
        output D_op, D_fuc, D_rs, D_rt, D_rd,
        input  stall, D_FWD_rs, D_FWD_rt, E_FWD_A1, E_FWD_A2, M_FWD_WD
    );

    modport slave (
        input  D_op, D_fuc, D_rs, D_rt, D_rd,
        output stall, D_FWD_rs, D_FWD_rt, E_FWD_A1, E_FWD_A2, M_FWD_WD
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for the 5-stage MIPS pipeline.
// Decodes the D instruction into Tuse/A3/Tnew, tracks in-flight writers in
// E/M/W and derives stall plus forwarding selects.
//   clk   : system clock
//   reset : synchronous, active-high
//   hz    : hazard_ctrl_if.slave (D fields in, stall/forward selects out)
module hazard_ctrl #(
    parameter logic [4:0] REG_ZERO = 5'd0,
    parameter logic [4:0] RA_REG   = 5'd31
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDEI = 6'b110011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_JR     = 6'b001000;

    // D decode; an unused source gets Tuse=3, which no Tnew can exceed
    logic [1:0] tuse_rs, tuse_rt, d_tnew;
    logic [4:0] d_a3;

    always_comb begin
        tuse_rs = 2'd3;
        tuse_rt = 2'd3;
        d_a3    = REG_ZERO;
        d_tnew  = 2'd0;
        case (hz.D_op)
            OP_RTYPE: begin
                case (hz.D_fuc)
                    F_ADD, F_SUB: begin
                        tuse_rs = 2'd1;
                        tuse_rt = 2'd1;
                        d_a3    = hz.D_rd;
                        d_tnew  = 2'd1;
                    end
                    F_JR:    tuse_rs = 2'd0;
                    default: ;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDEI: begin
                tuse_rs = 2'd1;
                d_a3    = hz.D_rt;
                d_tnew  = 2'd1;
            end
            OP_LW: begin
                tuse_rs = 2'd1;
                d_a3    = hz.D_rt;
                d_tnew  = 2'd2;
            end
            OP_SW: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd2;
            end
            OP_BEQ: begin
                tuse_rs = 2'd0;
                tuse_rt = 2'd0;
            end
            OP_JAL: begin
                d_a3   = RA_REG;
                d_tnew = 2'd0;
            end
            default: ;
        endcase
    end

    // in-flight writer scoreboard
    logic [4:0] e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
    logic [1:0] e_tnew, m_tnew;

    function automatic logic hit(input logic [4:0] a3, input logic [4:0] r);
        return (r != REG_ZERO) && (a3 == r);
    endfunction

    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt, stall_w;

    assign e_hit_rs = hit(e_a3, hz.D_rs);
    assign e_hit_rt = hit(e_a3, hz.D_rt);
    assign m_hit_rs = hit(m_a3, hz.D_rs);
    assign m_hit_rt = hit(m_a3, hz.D_rt);

    assign stall_w = (e_hit_rs && (tuse_rs < e_tnew)) ||
                     (m_hit_rs && (tuse_rs < m_tnew)) ||
                     (e_hit_rt && (tuse_rt < e_tnew)) ||
                     (m_hit_rt && (tuse_rt < m_tnew));

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_a3   <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
        end else begin
            if (stall_w) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_a3   <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= hz.D_rs;
                e_rt   <= hz.D_rt;
                e_a3   <= d_a3;
                e_tnew <= d_tnew;
            end
            // M and W keep draining while D is frozen
            m_rt   <= e_rt;
            m_a3   <= e_a3;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_a3   <= m_a3;
        end
    end

    // D forwarding: nearest writer wins; a writer not yet ready selects GRF
    // because the stall logic guarantees the value arrives before it is used
    function automatic logic [1:0] d_fwd(input logic eh, input logic mh);
        if (eh)      return (e_tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (mh) return (m_tnew == 2'd0) ? 2'd1 : 2'd0;
        else         return 2'd0;
    endfunction

    function automatic logic [1:0] e_fwd(input logic [4:0] r);
        if (hit(m_a3, r) && (m_tnew == 2'd0)) return 2'd1;
        else if (hit(w_a3, r))               return 2'd2;
        else                                  return 2'd0;
    endfunction

    assign hz.stall    = stall_w;
    assign hz.D_FWD_rs = d_fwd(e_hit_rs, m_hit_rs);
    assign hz.D_FWD_rt = d_fwd(e_hit_rt, m_hit_rt);
    assign hz.E_FWD_A1 = e_fwd(e_rs);
    assign hz.E_FWD_A2 = e_fwd(e_rt);
    assign hz.M_FWD_WD = hit(w_a3, m_rt);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences followed by random
// instruction streams, checked each cycle against a stage-list model.
module tb_hazard_ctrl;
    localparam logic [5:0] RT = 6'b000000, ORI = 6'b001101, LUI = 6'b001111,
                           ADDEI = 6'b110011, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, JAL = 6'b000011;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, JR = 6'b001000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hif();
    hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hif));

    typedef struct { logic [4:0] rs, rt, a3; int tnew; } ent_t;
    typedef struct { int tu_rs, tu_rt; logic [4:0] a3; int tnew; } dec_t;

    ent_t pipe [3];            // 0 = E, 1 = M, 2 = W
    int   n_cmp = 0, n_err = 0;
    logic [3:0] o_stall, o_drs, o_drt, o_ea1, o_ea2, o_mwd;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic dec_t decode(input logic [5:0] op, fuc, input logic [4:0] rt, rd);
        dec_t d = '{3, 3, 5'd0, 0};
        if (op == RT && (fuc == ADD || fuc == SUB)) d = '{1, 1, rd, 1};
        else if (op == RT && fuc == JR)             d = '{0, 3, 5'd0, 0};
        else if (op == ORI || op == LUI || op == ADDEI) d = '{1, 3, rt, 1};
        else if (op == LW)  d = '{1, 3, rt, 2};
        else if (op == SW)  d = '{1, 2, 5'd0, 0};
        else if (op == BEQ) d = '{0, 0, 5'd0, 0};
        else if (op == JAL) d = '{3, 3, 5'd31, 0};
        return d;
    endfunction

    function automatic bit hit(input int s, input logic [4:0] r);
        return (r != 5'd0) && (pipe[s].a3 == r);
    endfunction

    function automatic int dfwd(input logic [4:0] r);
        if (hit(0, r)) return (pipe[0].tnew == 0) ? 2 : 0;
        if (hit(1, r)) return (pipe[1].tnew == 0) ? 1 : 0;
        return 0;
    endfunction

    function automatic int efwd(input logic [4:0] r);
        if (hit(1, r) && pipe[1].tnew == 0) return 1;
        if (hit(2, r)) return 2;
        return 0;
    endfunction

    task automatic step(input logic [5:0] op, fuc, input logic [4:0] rs, rt, rd, input bit rst);
        dec_t d;
        int st, mwd;
        @(negedge clk);
        reset = rst;
        hif.D_op = op; hif.D_fuc = fuc; hif.D_rs = rs; hif.D_rt = rt; hif.D_rd = rd;
        #1;
        d  = decode(op, fuc, rt, rd);
        st = 0;
        for (int s = 0; s < 2; s++) begin
            if (hit(s, rs) && d.tu_rs < pipe[s].tnew) st = 1;
            if (hit(s, rt) && d.tu_rt < pipe[s].tnew) st = 1;
        end
        mwd = (pipe[1].rt != 5'd0 && pipe[2].a3 == pipe[1].rt) ? 1 : 0;
        o_stall = 4'(hif.stall);  o_drs = 4'(hif.D_FWD_rs); o_drt = 4'(hif.D_FWD_rt);
        o_ea1 = 4'(hif.E_FWD_A1); o_ea2 = 4'(hif.E_FWD_A2); o_mwd = 4'(hif.M_FWD_WD);
        chk("stall",    o_stall, 4'(st));
        chk("D_FWD_rs", o_drs,   4'(dfwd(rs)));
        chk("D_FWD_rt", o_drt,   4'(dfwd(rt)));
        chk("E_FWD_A1", o_ea1,   4'(efwd(pipe[0].rs)));
        chk("E_FWD_A2", o_ea2,   4'(efwd(pipe[0].rt)));
        chk("M_FWD_WD", o_mwd,   4'(mwd));
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < 3; s++) pipe[s] = '{5'd0, 5'd0, 5'd0, 0};
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
            pipe[0] = st ? '{5'd0, 5'd0, 5'd0, 0} : '{rs, rt, d.a3, d.tnew};
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(RT, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) pipe[s] = '{5'd0, 5'd0, 5'd0, 0};
        reset = 1'b1;
        hif.D_op = '0; hif.D_fuc = '0; hif.D_rs = '0; hif.D_rt = '0; hif.D_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 4'(hif.stall),    4'd0);
        chk("rst_drs",   4'(hif.D_FWD_rs), 4'd0);
        chk("rst_drt",   4'(hif.D_FWD_rt), 4'd0);
        chk("rst_ea1",   4'(hif.E_FWD_A1), 4'd0);
        chk("rst_ea2",   4'(hif.E_FWD_A2), 4'd0);
        chk("rst_mwd",   4'(hif.M_FWD_WD), 4'd0);

        // lw $1 ; beq $1,$2 -> two stall cycles, then GRF
        step(LW,  0, 5'd0, 5'd1, 5'd0, 0);
        step(BEQ, 0, 5'd1, 5'd2, 5'd0, 0); chk("lwbeq_s1", o_stall, 1);
        step(BEQ, 0, 5'd1, 5'd2, 5'd0, 0); chk("lwbeq_s2", o_stall, 1);
        step(BEQ, 0, 5'd1, 5'd2, 5'd0, 0); chk("lwbeq_s3", o_stall, 0);
        chk("lwbeq_drs", o_drs, 0);
        nops(3);

        // add $3,$1,$2 ; add $4,$3,$3 -> E forwards both from M
        step(RT, ADD, 5'd1, 5'd2, 5'd3, 0);
        step(RT, ADD, 5'd3, 5'd3, 5'd4, 0); chk("addadd_stall", o_stall, 0);
        nops(1); chk("addadd_a1", o_ea1, 1); chk("addadd_a2", o_ea2, 1);
        nops(3);

        // lw $5 ; sw $5,0($6) -> no stall, store data from W in M
        step(LW, 0, 5'd0, 5'd5, 5'd0, 0);
        step(SW, 0, 5'd6, 5'd5, 5'd0, 0); chk("lwsw_stall", o_stall, 0);
        nops(2); chk("lwsw_mwd", o_mwd, 1);
        nops(3);

        // jal ; jr $31 -> PC+8 forwarded from E
        step(JAL, 0, 5'd0, 5'd0, 5'd0, 0);
        step(RT, JR, 5'd31, 5'd0, 5'd0, 0);
        chk("jaljr_stall", o_stall, 0); chk("jaljr_drs", o_drs, 2);
        nops(3);

        // ori $7 ; nop ; beq $7,$0 -> forward from M
        step(ORI, 0, 5'd0, 5'd7, 5'd0, 0);
        nops(1);
        step(BEQ, 0, 5'd7, 5'd0, 5'd0, 0);
        chk("oribeq_stall", o_stall, 0); chk("oribeq_drs", o_drs, 1);
        // writer of $0 followed by reader of $0
        step(RT, ADD, 5'd1, 5'd2, 5'd0, 0);
        step(RT, ADD, 5'd0, 5'd0, 5'd5, 0);
        chk("r0_stall", o_stall, 0); chk("r0_drs", o_drs, 0); chk("r0_drt", o_drt, 0);
        nops(1); chk("r0_ea1", o_ea1, 0); chk("r0_ea2", o_ea2, 0);
        nops(3);

        // reset during a lw-induced stall
        step(LW,  0, 5'd0, 5'd1, 5'd0, 0);
        step(BEQ, 0, 5'd1, 5'd2, 5'd0, 0); chk("rststall_pre", o_stall, 1);
        step(BEQ, 0, 5'd1, 5'd2, 5'd0, 1);
        step(BEQ, 0, 5'd1, 5'd2, 5'd0, 0);
        chk("rststall_stall", o_stall, 0); chk("rststall_drs", o_drs, 0);
        chk("rststall_ea1", o_ea1, 0);     chk("rststall_mwd", o_mwd, 0);

        // random instruction stream over a small register window
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fuc;
            fuc = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 10))
                0: begin op = RT; fuc = ADD; end
                1: begin op = RT; fuc = SUB; end
                2: begin op = RT; fuc = JR;  end
                3: op = RT;
                4: op = ORI;
                5: op = LUI;
                6: op = ADDEI;
                7: op = LW;
                8: op = SW;
                9: op = BEQ;
                default: op = ($urandom_range(0, 1) != 0) ? JAL : 6'($urandom_range(0, 63));
            endcase
            step(op, fuc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
